inst_encoder: RTL and testbench

Instruction assembler that packs RV32I fields (opcode, registers, funct bits, 32-bit immediate) into a 32-bit instruction word. It is the inverse of the immediate decode path in the core: it scatters the immediate into the I/S/B/U/J bit positions the decoder gathers from. It sits between the debug/boot loader and instruction memory. Each request passes a valid/ready handshake, is range-checked and encoded, and is queued in a 2-entry output FIFO with its own valid/ready handshake. Running counts of encoded and rejected requests are kept.

---
 rtl/inst_encoder.sv | 164 ++++++++++++++++
 tb/tb_inst_encoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// inst_encoder
//   RV32I instruction assembler: range-checks and packs fields into a 32-bit
//   word, queued in a 2-entry output FIFO with saturating result counters.
//   Revision: 1.0
// ============================================================================
module inst_encoder (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic [15:0] enc_count_o,
  output logic [15:0] err_count_o
);

  localparam logic [2:0]  FMT_R   = 3'd0;
  localparam logic [2:0]  FMT_I   = 3'd1;
  localparam logic [2:0]  FMT_S   = 3'd2;
  localparam logic [2:0]  FMT_B   = 3'd3;
  localparam logic [2:0]  FMT_U   = 3'd4;
  localparam logic [2:0]  FMT_J   = 3'd5;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [31:0] enc_word;
  logic        bad_imm;
  logic        bad_fmt;
  logic        enc_err;
  logic [31:0] enc_instr;

  logic        push;
  logic        pop;

  logic [1:0]  count_q, count_d;
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [31:0] mem_instr_q [2];
  logic [31:0] mem_instr_d [2];
  logic        mem_err_q [2];
  logic        mem_err_d [2];
  logic [31:0] last_instr_q, last_instr_d;
  logic        last_err_q, last_err_d;
  logic [15:0] enc_count_q, enc_count_d;
  logic [15:0] err_count_q, err_count_d;

  // Immediate range checks test that the discarded upper bits are pure sign extension.
  always_comb begin
    enc_word = 32'h0;
    bad_imm  = 1'b0;
    bad_fmt  = 1'b0;
    case (fmt_i)
      FMT_R: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: begin
        enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        bad_imm  = !((&imm_i[31:11]) || !(|imm_i[31:11]));
      end
      FMT_S: begin
        enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        bad_imm  = !((&imm_i[31:11]) || !(|imm_i[31:11]));
      end
      FMT_B: begin
        enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                    imm_i[4:1], imm_i[11], opcode_i};
        bad_imm  = !((&imm_i[31:12]) || !(|imm_i[31:12])) || imm_i[0];
      end
      FMT_U: begin
        enc_word = {imm_i[31:12], rd_i, opcode_i};
        bad_imm  = |imm_i[11:0];
      end
      FMT_J: begin
        enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        bad_imm  = !((&imm_i[31:20]) || !(|imm_i[31:20])) || imm_i[0];
      end
      default: bad_fmt = 1'b1;
    endcase
    enc_err   = bad_fmt || bad_imm || (opcode_i[1:0] != 2'b11);
    enc_instr = enc_err ? 32'h0 : enc_word;
  end

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  // Outputs fall back to the last popped entry so they stay stable while empty.
  assign instr_o     = out_valid_o ? mem_instr_q[rptr_q] : last_instr_q;
  assign err_o       = out_valid_o ? mem_err_q[rptr_q]   : last_err_q;
  assign enc_count_o = enc_count_q;
  assign err_count_o = err_count_q;

  always_comb begin
    count_d      = count_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    mem_instr_d  = mem_instr_q;
    mem_err_d    = mem_err_q;
    last_instr_d = last_instr_q;
    last_err_d   = last_err_q;
    enc_count_d  = enc_count_q;
    err_count_d  = err_count_q;
    if (push) begin
      mem_instr_d[wptr_q] = enc_instr;
      mem_err_d[wptr_q]   = enc_err;
      wptr_d              = ~wptr_q;
      if (enc_err) begin
        if (err_count_q != CNT_MAX) err_count_d = err_count_q + 16'd1;
      end else begin
        if (enc_count_q != CNT_MAX) enc_count_d = enc_count_q + 16'd1;
      end
    end
    if (pop) begin
      last_instr_d = mem_instr_q[rptr_q];
      last_err_d   = mem_err_q[rptr_q];
      rptr_d       = ~rptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q        <= 2'd0;
      wptr_q         <= 1'b0;
      rptr_q         <= 1'b0;
      mem_instr_q[0] <= 32'h0;
      mem_instr_q[1] <= 32'h0;
      mem_err_q[0]   <= 1'b0;
      mem_err_q[1]   <= 1'b0;
      last_instr_q   <= 32'h0;
      last_err_q     <= 1'b0;
      enc_count_q    <= 16'h0;
      err_count_q    <= 16'h0;
    end else begin
      count_q        <= count_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      mem_instr_q[0] <= mem_instr_d[0];
      mem_instr_q[1] <= mem_instr_d[1];
      mem_err_q[0]   <= mem_err_d[0];
      mem_err_q[1]   <= mem_err_d[1];
      last_instr_q   <= last_instr_d;
      last_err_q     <= last_err_d;
      enc_count_q    <= enc_count_d;
      err_count_q    <= err_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// tb_inst_encoder
//   Randomized and directed bench for inst_encoder with a queue-based model.
//   Revision: 1.0
// ============================================================================
module tb_inst_encoder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  fmt_i = '0;
  logic [6:0]  opcode_i = '0;
  logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [6:0]  funct7_i = '0;
  logic [31:0] imm_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic        err_o;
  logic [15:0] enc_count_o;
  logic [15:0] err_count_o;

  inst_encoder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .fmt_i(fmt_i), .opcode_i(opcode_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .instr_o(instr_o), .err_o(err_o),
    .enc_count_o(enc_count_o), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_last = '0;
  int          exp_enc = 0;
  int          exp_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned field(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 1);
  endfunction

  // Reference: legality by signed range, encoding by shift-and-add of each field.
  function automatic logic [32:0] ref_enc();
    int          s;
    bit          bad;
    int unsigned w;
    s   = $signed(imm_i);
    bad = (opcode_i % 4 != 3) || (fmt_i > 5);
    w   = 0;
    case (fmt_i)
      3'd1, 3'd2: bad = bad || s < -2048 || s > 2047;
      3'd3:       bad = bad || s < -4096 || s > 4095 || (s % 2 != 0);
      3'd5:       bad = bad || s < -(1 << 20) || s >= (1 << 20) || (s % 2 != 0);
      3'd4:       bad = bad || (imm_i % 4096 != 0);
      default:    ;
    endcase
    case (fmt_i)
      3'd0: w = funct7_i * (1 << 25) + rs2_i * (1 << 20) + rs1_i * (1 << 15)
                + funct3_i * (1 << 12) + rd_i * (1 << 7) + opcode_i;
      3'd1: w = field(imm_i, 11, 0) * (1 << 20) + rs1_i * (1 << 15)
                + funct3_i * (1 << 12) + rd_i * (1 << 7) + opcode_i;
      3'd2: w = field(imm_i, 11, 5) * (1 << 25) + rs2_i * (1 << 20) + rs1_i * (1 << 15)
                + funct3_i * (1 << 12) + field(imm_i, 4, 0) * (1 << 7) + opcode_i;
      3'd3: w = field(imm_i, 12, 12) * (1 << 31) + field(imm_i, 10, 5) * (1 << 25)
                + rs2_i * (1 << 20) + rs1_i * (1 << 15) + funct3_i * (1 << 12)
                + field(imm_i, 4, 1) * (1 << 8) + field(imm_i, 11, 11) * (1 << 7) + opcode_i;
      3'd4: w = field(imm_i, 31, 12) * (1 << 12) + rd_i * (1 << 7) + opcode_i;
      3'd5: w = field(imm_i, 20, 20) * (1 << 31) + field(imm_i, 10, 1) * (1 << 21)
                + field(imm_i, 11, 11) * (1 << 20) + field(imm_i, 19, 12) * (1 << 12)
                + rd_i * (1 << 7) + opcode_i;
      default: w = 0;
    endcase
    if (bad) w = 0;
    return {bad, w};
  endfunction

  // One clock: score the handshakes about to happen, advance, then check state.
  task automatic step(output bit pushed);
    bit          pop;
    logic [32:0] r;
    #1;
    pushed = in_valid_i && in_ready_o;
    pop    = out_valid_o && out_ready_i;
    if (exp_q.size() == 0) begin
      check("held_instr", instr_o, exp_last[31:0]);
      check("held_err", {31'd0, err_o}, {31'd0, exp_last[32]});
    end
    if (pop) begin
      if (exp_q.size() == 0) begin
        check("pop_empty", 32'd1, 32'd0);
      end else begin
        check("head_instr", instr_o, exp_q[0][31:0]);
        check("head_err", {31'd0, err_o}, {31'd0, exp_q[0][32]});
        exp_last = exp_q.pop_front();
      end
    end
    if (pushed) begin
      r = ref_enc();
      exp_q.push_back(r);
      if (r[32]) begin if (exp_err < 65535) exp_err++; end
      else       begin if (exp_enc < 65535) exp_enc++; end
    end
    @(posedge clk_i);
    #1;
    check("out_valid", {31'd0, out_valid_o}, {31'd0, exp_q.size() != 0});
    check("in_ready", {31'd0, in_ready_o}, {31'd0, exp_q.size() < 2});
    check("enc_count", {16'd0, enc_count_o}, exp_enc);
    check("err_count", {16'd0, err_count_o}, exp_err);
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                         input logic [31:0] imm);
    fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = r1; rs2_i = r2;
    funct3_i = f3; funct7_i = 7'h20; imm_i = imm;
  endtask

  task automatic rand_req();
    int k;
    fmt_i    = 3'($urandom_range(0, 7));
    opcode_i = ($urandom_range(0, 7) == 0) ? 7'($urandom) : {5'($urandom), 2'b11};
    rd_i = 5'($urandom); rs1_i = 5'($urandom); rs2_i = 5'($urandom);
    funct3_i = 3'($urandom); funct7_i = 7'($urandom);
    k = $urandom_range(0, 3);
    case (k)
      0: imm_i = 32'($urandom_range(0, 8191)) - 32'd4096;
      1: imm_i = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      2: imm_i = $urandom & 32'hFFFF_F000;
      default: imm_i = $urandom;
    endcase
  endtask

  // Offer the current request until accepted, bounded.
  task automatic send();
    bit p;
    int n;
    n = 0;
    in_valid_i = 1'b1;
    do begin
      step(p);
      n++;
    end while (!p && n < 20);
    if (!p) check("send_timeout", 32'd0, 32'd1);
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    bit p;
    for (int i = 0; i < n; i++) step(p);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid_o}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready_o}, 32'd1);
    check({tag, "_instr"}, instr_o, 32'd0);
    check({tag, "_err"}, {31'd0, err_o}, 32'd0);
    check({tag, "_enc"}, {16'd0, enc_count_o}, 32'd0);
    check({tag, "_errc"}, {16'd0, err_count_o}, 32'd0);
  endtask

  initial begin
    bit p;
    int base;
    #3;
    reset_checks("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Directed encodings with the sink always ready.
    out_ready_i = 1'b1;
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    send(); check("addi", instr_o, 32'h00500093); check("addi_err", {31'd0, err_o}, 32'd0);
    set_req(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    send(); check("sw", instr_o, 32'h0020A423); check("sw_err", {31'd0, err_o}, 32'd0);
    set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
    send(); check("beq", instr_o, 32'hFE000EE3); check("beq_err", {31'd0, err_o}, 32'd0);
    set_req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800);
    send(); check("jal", instr_o, 32'h001000EF); check("jal_err", {31'd0, err_o}, 32'd0);
    set_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    send(); check("lui", instr_o, 32'h123452B7); check("lui_err", {31'd0, err_o}, 32'd0);

    // Error requests.
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    send(); check("ierr_instr", instr_o, 32'd0); check("ierr_err", {31'd0, err_o}, 32'd1);
    set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
    send(); check("berr_instr", instr_o, 32'd0); check("berr_err", {31'd0, err_o}, 32'd1);
    set_req(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
    send(); check("ferr_instr", instr_o, 32'd0); check("ferr_err", {31'd0, err_o}, 32'd1);
    check("errs_errcount", {16'd0, err_count_o}, 32'd3);
    check("errs_enccount", {16'd0, enc_count_o}, 32'd5);
    idle(2);

    // Backpressure: two accepts fill the FIFO; the third waits for a drain.
    out_ready_i = 1'b0;
    set_req(3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 32'd0); send();
    set_req(3'd1, 7'h13, 5'd6, 5'd7, 5'd0, 3'd1, 32'd100); send();
    check("bp_full_ready", {31'd0, in_ready_o}, 32'd0);
    set_req(3'd4, 7'h17, 5'd8, 5'd0, 5'd0, 3'd0, 32'hABCD_E000);
    in_valid_i = 1'b1;
    out_ready_i = 1'b1;
    step(p);
    check("bp_no_push_on_pop", {31'd0, p}, 32'd0);
    check("bp_ready_after_pop", {31'd0, in_ready_o}, 32'd1);
    send();
    idle(4);

    // Simultaneous push/pop at occupancy 1.
    out_ready_i = 1'b0;
    set_req(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0); send();
    out_ready_i = 1'b1;
    base = exp_enc;
    in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(3'd0, 7'h33, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), $urandom);
      step(p);
      check("pp_occupancy", {31'd0, out_valid_o && in_ready_o}, 32'd1);
    end
    in_valid_i = 1'b0;
    check("pp_enc_delta", {16'd0, enc_count_o}, base + 10);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_req();
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      step(p);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    idle(3);

    // Reset mid-operation with two entries queued.
    out_ready_i = 1'b0;
    rand_req(); fmt_i = 3'd0; opcode_i = 7'h33; send();
    rand_req(); fmt_i = 3'd0; opcode_i = 7'h33; send();
    #2;
    rst_ni = 1'b0;
    #1;
    reset_checks("midrst");
    exp_q.delete();
    exp_last = '0;
    exp_enc = 0;
    exp_err = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    send(); check("post_rst_addi", instr_o, 32'h00500093);
    idle(2);

    // Saturation of the good-request counter.
    @(negedge clk_i);
    force dut.enc_count_q = 16'hFFFE;
    #1;
    release dut.enc_count_q;
    exp_enc = 65534;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) begin
      set_req(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 32'd1);
      send();
    end
    check("sat_enc", {16'd0, enc_count_o}, 32'h0000_FFFF);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
